tiny_rv_rr: RTL and testbench

//  Register-read/decode stage, directly upstream of the execute stage. Captures fetched

---
 rtl/tiny_rv_rr.sv | 179 +++++++++++++++++
 tb/tb_tiny_rv_rr.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tiny_rv_rr.sv
// ---------------------------------------------------------------------------
// tiny_rv_rr : register-read / decode stage, sits directly before execute.
//
// Captures one fetched instruction per cycle and splits it into its decoded
// fields and immediate. It reads the 32x32 integer register file and resolves
// read-after-write hazards by forwarding from execute and writeback. The result
// is presented as one registered instruction on the rr_* outputs.
//
// Ports
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   if_valid/pc/inst      instruction presented by fetch
//   rr_if_stall           fetch must hold if_* (combinational)
//   exec_rr_stall         execute cannot accept; hold rr_* outputs
//   exec_rr_flush         branch taken; kill the instruction being captured
//   of1_reg/of1_val       rd and result of the instruction now in execute
//   exec_rd/exec_rd_val   rd and value of the execute output register
//   wb_we/wb_rd/wb_val    register-file write port
//   rr_*                  registered PC, instruction, decoded fields,
//                         forwarded operands and sign-extended immediate
// ---------------------------------------------------------------------------
module tiny_rv_rr #(
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        rr_if_stall,
  input  logic        exec_rr_stall,
  input  logic        exec_rr_flush,
  input  logic [4:0]  of1_reg,
  input  logic [31:0] of1_val,
  input  logic [4:0]  exec_rd,
  input  logic [31:0] exec_rd_val,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  output logic [31:0] rr_pc,
  output logic [31:0] rr_inst,
  output logic [6:0]  rr_opcode,
  output logic [4:0]  rr_rd,
  output logic [2:0]  rr_funct3,
  output logic [6:0]  rr_funct7,
  output logic [31:0] rr_rs1,
  output logic [31:0] rr_rs2,
  output logic [31:0] rr_imm32
);

  // Register file storage. Deliberately not reset; entry 0 is never written
  // and is never used as a read value because x0 is decoded to zero first.
  logic [31:0] regs_r [32];

  logic        hold_s;
  logic [31:0] src_inst_s;
  logic [4:0]  rs1_idx_s;
  logic [4:0]  rs2_idx_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] imm_s;

  // Sign-extended immediate selected by the instruction format of the opcode.
  function automatic logic [31:0] decode_imm(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        imm = {{20{inst[31]}}, inst[31:20]};
      7'b0100011:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'b1100011:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {inst[31:12], 12'h000};
      7'b1101111:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // Operand value for one source register; the youngest producer wins, so the
  // checks run from execute back towards the register file.
  function automatic logic [31:0] select_operand(
    input logic [4:0]  rs,
    input logic [31:0] rf_val,
    input logic [4:0]  f_of1_reg,
    input logic [31:0] f_of1_val,
    input logic [4:0]  f_exec_rd,
    input logic [31:0] f_exec_val,
    input logic        f_wb_we,
    input logic [4:0]  f_wb_rd,
    input logic [31:0] f_wb_val
  );
    logic [31:0] val;
    if (rs == 5'd0) begin
      val = 32'h0000_0000;
    end else if (rs == f_of1_reg) begin
      val = f_of1_val;
    end else if (rs == f_exec_rd) begin
      val = f_exec_val;
    end else if (WB_BYPASS && f_wb_we && (rs == f_wb_rd)) begin
      val = f_wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  // Stall holds the stage unless a flush overrides it.
  assign hold_s      = exec_rr_stall & ~exec_rr_flush;
  assign rr_if_stall = hold_s;

  // Source selection: while held, operands are re-read from the held
  // instruction so values from producers that drain during the stall survive.
  always_comb begin
    src_inst_s = if_inst;
    if (hold_s) begin
      src_inst_s = rr_inst;
    end else begin
      src_inst_s = if_inst;
    end
    rs1_idx_s = src_inst_s[19:15];
    rs2_idx_s = src_inst_s[24:20];
    rs1_val_s = select_operand(rs1_idx_s, regs_r[rs1_idx_s], of1_reg, of1_val,
                               exec_rd, exec_rd_val, wb_we, wb_rd, wb_val);
    rs2_val_s = select_operand(rs2_idx_s, regs_r[rs2_idx_s], of1_reg, of1_val,
                               exec_rd, exec_rd_val, wb_we, wb_rd, wb_val);
    imm_s     = decode_imm(if_inst);
  end

  // Register file write port; runs regardless of stall or flush, x0 is dropped.
  always_ff @(posedge i_clk) begin
    if (wb_we && (wb_rd != 5'd0)) begin
      regs_r[wb_rd] <= wb_val;
    end
  end

  // Output pipeline register: flush > stall > bubble on invalid > capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr_pc     <= 32'h0000_0000;
      rr_inst   <= NOP_INST;
      rr_opcode <= 7'd0;
      rr_rd     <= 5'd0;
      rr_funct3 <= 3'd0;
      rr_funct7 <= 7'd0;
      rr_rs1    <= 32'h0000_0000;
      rr_rs2    <= 32'h0000_0000;
      rr_imm32  <= 32'h0000_0000;
    end else if (exec_rr_flush || !(exec_rr_stall || if_valid)) begin
      rr_pc     <= 32'h0000_0000;
      rr_inst   <= NOP_INST;
      rr_opcode <= 7'd0;
      rr_rd     <= 5'd0;
      rr_funct3 <= 3'd0;
      rr_funct7 <= 7'd0;
      rr_rs1    <= 32'h0000_0000;
      rr_rs2    <= 32'h0000_0000;
      rr_imm32  <= 32'h0000_0000;
    end else if (exec_rr_stall) begin
      // Decoded fields hold; only the operands are refreshed.
      rr_rs1    <= rs1_val_s;
      rr_rs2    <= rs2_val_s;
    end else begin
      rr_pc     <= if_pc;
      rr_inst   <= if_inst;
      rr_opcode <= if_inst[6:0];
      rr_rd     <= if_inst[11:7];
      rr_funct3 <= if_inst[14:12];
      rr_funct7 <= if_inst[31:25];
      rr_rs1    <= rs1_val_s;
      rr_rs2    <= rs2_val_s;
      rr_imm32  <= imm_s;
    end
  end

endmodule

// File: tb/tb_tiny_rv_rr.sv
module tb_tiny_rv_rr;

  logic        i_clk;
  logic        i_reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        rr_if_stall;
  logic        exec_rr_stall;
  logic        exec_rr_flush;
  logic [4:0]  of1_reg;
  logic [31:0] of1_val;
  logic [4:0]  exec_rd;
  logic [31:0] exec_rd_val;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic [31:0] rr_pc;
  logic [31:0] rr_inst;
  logic [6:0]  rr_opcode;
  logic [4:0]  rr_rd;
  logic [2:0]  rr_funct3;
  logic [6:0]  rr_funct7;
  logic [31:0] rr_rs1;
  logic [31:0] rr_rs2;
  logic [31:0] rr_imm32;

  int checks;
  int failures;

  tiny_rv_rr dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .rr_if_stall   (rr_if_stall),
    .exec_rr_stall (exec_rr_stall),
    .exec_rr_flush (exec_rr_flush),
    .of1_reg       (of1_reg),
    .of1_val       (of1_val),
    .exec_rd       (exec_rd),
    .exec_rd_val   (exec_rd_val),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_val        (wb_val),
    .rr_pc         (rr_pc),
    .rr_inst       (rr_inst),
    .rr_opcode     (rr_opcode),
    .rr_rd         (rr_rd),
    .rr_funct3     (rr_funct3),
    .rr_funct7     (rr_funct7),
    .rr_rs1        (rr_rs1),
    .rr_rs2        (rr_rs2),
    .rr_imm32      (rr_imm32)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_pc"},     rr_pc,              32'h0000_0000);
    check({tag, "_inst"},   rr_inst,            32'h0000_0013);
    check({tag, "_opcode"}, {25'd0, rr_opcode}, 32'd0);
    check({tag, "_rd"},     {27'd0, rr_rd},     32'd0);
    check({tag, "_rs1"},    rr_rs1,             32'd0);
    check({tag, "_imm"},    rr_imm32,           32'd0);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_reset = 1'b1;
    if_valid = 1'b0; if_pc = 32'd0; if_inst = 32'd0;
    exec_rr_stall = 1'b0; exec_rr_flush = 1'b0;
    of1_reg = 5'd0; of1_val = 32'd0; exec_rd = 5'd0; exec_rd_val = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_val = 32'd0;
    #12;
    check_bubble("reset");
    check("reset_if_stall", {31'd0, rr_if_stall}, 32'd0);
    i_reset = 1'b0;

    // x5 = 0x11 through the write port.
    wb_we = 1'b1; wb_rd = 5'd5; wb_val = 32'h11;
    tick();
    wb_we = 1'b0;

    // add x1,x5,x0 with both forwarding sources naming x5.
    of1_reg = 5'd5; of1_val = 32'h22; exec_rd = 5'd5; exec_rd_val = 32'h33;
    issue(32'h40, 32'h0002_80B3);
    check("fwd_of1_rs1", rr_rs1, 32'h22);
    check("fwd_of1_rs2", rr_rs2, 32'h0);
    check("add_pc", rr_pc, 32'h40);
    check("add_opcode", {25'd0, rr_opcode}, 32'h33);
    check("add_rd", {27'd0, rr_rd}, 32'd1);
    check("add_imm", rr_imm32, 32'd0);
    of1_reg = 5'd0;
    issue(32'h44, 32'h0002_80B3);
    check("fwd_exec_rs1", rr_rs1, 32'h33);
    exec_rd = 5'd0;
    issue(32'h48, 32'h0002_80B3);
    check("regfile_rs1", rr_rs1, 32'h11);

    // Write to x0 is dropped; then addi x1,x0,0 reads zero.
    wb_we = 1'b1; wb_rd = 5'd0; wb_val = 32'hFFFF_FFFF;
    issue(32'h4C, 32'h0000_0093);
    wb_we = 1'b0;
    issue(32'h50, 32'h0000_0093);
    check("x0_reads_zero", rr_rs1, 32'd0);

    // add x2,x7,x7 with same-cycle writeback of x7.
    wb_we = 1'b1; wb_rd = 5'd7; wb_val = 32'h0000_ABCD;
    issue(32'h54, 32'h0073_8133);
    check("wb_bypass_rs1", rr_rs1, 32'h0000_ABCD);
    check("wb_bypass_rs2", rr_rs2, 32'h0000_ABCD);
    wb_we = 1'b0;
    issue(32'h100, 32'h0073_8133);
    check("x7_written", rr_rs1, 32'h0000_ABCD);

    // Three stalled cycles with a different instruction waiting at fetch.
    exec_rr_stall = 1'b1;
    if_pc = 32'h200; if_inst = 32'hFFF0_0093;
    #1;
    check("stall_if_stall", {31'd0, rr_if_stall}, 32'd1);
    tick();
    check("stall1_pc", rr_pc, 32'h100);
    check("stall1_inst", rr_inst, 32'h0073_8133);
    of1_reg = 5'd7; of1_val = 32'h55;
    tick();
    check("stall2_rs1_refresh", rr_rs1, 32'h55);
    check("stall2_rs2_refresh", rr_rs2, 32'h55);
    check("stall2_pc", rr_pc, 32'h100);
    of1_reg = 5'd0;
    tick();
    check("stall3_rs1_drained", rr_rs1, 32'h0000_ABCD);
    check("stall3_rd", {27'd0, rr_rd}, 32'd2);
    check("stall3_if_stall", {31'd0, rr_if_stall}, 32'd1);

    // Flush overrides stall.
    exec_rr_flush = 1'b1;
    #1;
    check("flush_if_stall", {31'd0, rr_if_stall}, 32'd0);
    tick();
    check_bubble("flush");
    exec_rr_flush = 1'b0; exec_rr_stall = 1'b0;

    // Immediates for each format.
    issue(32'h300, 32'hFE00_0EE3);
    check("imm_b", rr_imm32, 32'hFFFF_FFFC);
    issue(32'h304, 32'h8000_00EF);
    check("imm_j", rr_imm32, 32'hFFF0_0000);
    issue(32'h308, 32'hFFF0_0093);
    check("imm_i", rr_imm32, 32'hFFFF_FFFF);
    check("imm_i_rd", {27'd0, rr_rd}, 32'd1);
    issue(32'h30C, 32'h8000_0FA3);
    check("imm_s", rr_imm32, 32'hFFFF_F81F);
    issue(32'h310, 32'h1234_5037);
    check("imm_u", rr_imm32, 32'h1234_5000);
    check("u_funct7", {25'd0, rr_funct7}, 32'h09);
    check("u_funct3", {29'd0, rr_funct3}, 32'd5);

    // One invalid cycle between instructions gives exactly one bubble.
    if_valid = 1'b0;
    tick();
    check_bubble("invalid");
    issue(32'h314, 32'h0002_80B3);
    check("after_bubble_pc", rr_pc, 32'h314);
    check("after_bubble_rs1", rr_rs1, 32'h11);

    // Asynchronous reset in the middle of a stall, checked before any edge.
    exec_rr_stall = 1'b1;
    tick();
    check("pre_reset_held", rr_pc, 32'h314);
    #2;
    i_reset = 1'b1;
    #1;
    check_bubble("async_reset");
    #3;
    i_reset = 1'b0;
    exec_rr_stall = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
